// File: rtl/regfile_sb.sv
// Integer register file with N combinational read ports, one writeback port and
// same-cycle write-to-read bypass, plus a saturating outstanding-writer scoreboard.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int CNTW     = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush,
    output logic [1:0]          err
);

    localparam int              DEPTH = 1 << AW;
    localparam logic [CNTW-1:0] CMAX  = '1;

    logic [XLEN-1:0] regs [DEPTH];
    logic [CNTW-1:0] cnt  [DEPTH];
    logic [DEPTH-1:0] live;

    logic [AW-1:0]   ra   [NRD];
    logic [CNTW-1:0] rcnt [NRD];
    logic [NRD-1:0]  hit;

    logic            wr_live;
    logic            wr_dec;
    logic            iss_acc;
    logic [CNTW-1:0] wr_cnt;
    logic [CNTW-1:0] iss_cnt;

    // Saturating counter step; inc and dec together cancel.
    function automatic logic [CNTW-1:0] cnt_next(input logic [CNTW-1:0] c,
                                                 input logic inc, input logic dec);
        if (inc && !dec && c != CMAX) return c + 1'b1;
        if (dec && !inc && c != '0)   return c - 1'b1;
        return c;
    endfunction

    // An address is live when it is in range and not the hardwired zero register.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++)
            live[i] = (i < NREG) && !((ZERO_REG != 0) && (i == 0));
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        hit     = '0;
        ra      = '{default: '0};
        rcnt    = '{default: '0};
        for (int k = 0; k < NRD; k++) begin
            ra[k]   = rd_addr[k*AW +: AW];
            hit[k]  = (BYPASS != 0) && wr_en && (wr_addr == ra[k]) && live[ra[k]];
            rcnt[k] = live[ra[k]] ? cnt[ra[k]] : '0;
            if (live[ra[k]])
                rd_data[k*XLEN +: XLEN] = hit[k] ? wr_data : regs[ra[k]];
            // A retiring writeback hides exactly one outstanding writer.
            rd_busy[k] = rcnt[k] > CNTW'(hit[k]);
        end
    end

    assign wr_live   = wr_en && live[wr_addr];
    assign wr_cnt    = live[wr_addr] ? cnt[wr_addr] : '0;
    assign iss_cnt   = live[iss_rd]  ? cnt[iss_rd]  : '0;
    assign wr_dec    = wr_live && (wr_cnt != '0);
    assign iss_ready = (iss_cnt != CMAX) ||
                       (wr_en && (wr_addr == iss_rd) && (iss_cnt != '0));
    assign iss_acc   = iss_en && iss_ready && !flush && live[iss_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err <= '0;
        end else begin
            if (wr_live) regs[wr_addr] <= wr_data;
            for (int r = 0; r < DEPTH; r++) begin
                if (flush)
                    cnt[r] <= '0;
                else
                    cnt[r] <= cnt_next(cnt[r], iss_acc && (iss_rd == AW'(r)),
                                       wr_dec && (wr_addr == AW'(r)));
            end
            if (wr_live && (wr_cnt == '0))    err[0] <= 1'b1;
            if (iss_en && !iss_ready && !flush) err[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: driver predicts each cycle's outputs from a
// behavioural model and queues them; a negedge monitor pops and compares.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int CMAX = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [XLEN-1:0]     wr_data = '0;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_rd = '0;
    logic                iss_ready;
    logic                flush = 1'b0;
    logic [1:0]          err;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .CNTW(2),
                 .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .flush(flush), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  id;
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
        logic                ready;
        logic [1:0]          err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    // Reference state: architectural values and outstanding-writer counts.
    logic [XLEN-1:0] m_mem [NREG];
    int              m_cnt [NREG];
    logic [1:0]      m_err;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_mem[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 2'b00;
    endtask

    function automatic bit real_reg(input int a);
        return (a != 0) && (a < NREG);
    endfunction

    task automatic chk(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, want);
        end
    endtask

    task automatic step(input logic r, input int a0, input int a1,
                        input logic we, input int wa, input logic [XLEN-1:0] wd,
                        input logic ie, input int ia, input logic fl);
        exp_t e;
        bit   rdy, acc, dec, wl, h;
        int   a;
        @(posedge clk);
        #1;
        rst     = r;
        rd_addr = {AW'(a1), AW'(a0)};
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        iss_en  = ie;
        iss_rd  = AW'(ia);
        flush   = fl;
        if (r) model_reset();

        e.id   = step_id++;
        e.data = '0;
        e.busy = '0;
        for (int k = 0; k < NRD; k++) begin
            a = (k == 0) ? a0 : a1;
            if (real_reg(a)) begin
                h = we && (wa == a);
                e.data[k*XLEN +: XLEN] = h ? wd : m_mem[a];
                e.busy[k] = m_cnt[a] > (h ? 1 : 0);
            end
        end
        rdy = !real_reg(ia) || (m_cnt[ia] < CMAX) || (we && wa == ia && m_cnt[ia] > 0);
        e.ready = rdy;
        e.err   = m_err;
        q.push_back(e);

        if (!r) begin
            wl  = we && real_reg(wa);
            acc = ie && rdy && !fl && real_reg(ia);
            dec = wl && m_cnt[wa] > 0;
            if (wl && m_cnt[wa] == 0) m_err[0] = 1'b1;
            if (ie && !rdy && !fl)    m_err[1] = 1'b1;
            if (wl) m_mem[wa] = wd;
            if (fl) begin
                for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
            end else begin
                if (dec) m_cnt[wa] = m_cnt[wa] - 1;
                if (acc) m_cnt[ia] = m_cnt[ia] + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_data",   e.id, 64'(rd_data),   64'(e.data));
            chk("rd_busy",   e.id, 64'(rd_busy),   64'(e.busy));
            chk("iss_ready", e.id, 64'(iss_ready), 64'(e.ready));
            chk("err",       e.id, 64'(err),       64'(e.err));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        model_reset();
        //   rst a0 a1 we wa wd            ie ia fl
        step(1, 0, 5, 0, 0, 0,            0, 0, 0);
        // Unreserved writeback: bypassed now, stored next cycle, underflow flagged.
        step(0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        step(0, 5, 5, 0, 0, 0,            0, 0, 0);
        // Issue x7, observe busy, retire with bypass.
        step(0, 7, 0, 0, 0, 0,            1, 7, 0);
        step(0, 7, 7, 0, 0, 0,            0, 0, 0);
        step(0, 7, 5, 1, 7, 32'h1234,     0, 0, 0);
        step(0, 7, 7, 0, 0, 0,            0, 7, 0);
        // Saturate x3, overflow drop, then issue accepted against a retire.
        step(0, 3, 0, 0, 0, 0,            1, 3, 0);
        step(0, 3, 0, 0, 0, 0,            1, 3, 0);
        step(0, 3, 0, 0, 0, 0,            1, 3, 0);
        step(0, 3, 0, 0, 0, 0,            1, 3, 0);
        step(0, 3, 0, 1, 3, 32'h33,       1, 3, 0);
        step(0, 3, 3, 0, 0, 0,            0, 3, 0);
        // Simultaneous issue and writeback on x9 with one writer outstanding.
        step(0, 9, 0, 0, 0, 0,            1, 9, 0);
        step(0, 9, 0, 1, 9, 32'h99,       1, 9, 0);
        step(0, 9, 9, 0, 0, 0,            0, 9, 0);
        // Zero register ignores writes and issues.
        step(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0,            0, 0, 0);
        // Flush with a concurrent writeback.
        step(0, 4, 6, 0, 0, 0,            1, 4, 0);
        step(0, 4, 6, 0, 0, 0,            1, 6, 0);
        step(0, 6, 4, 1, 4, 32'hAA,       0, 0, 1);
        step(0, 6, 4, 0, 0, 0,            0, 4, 0);
        // Reset mid-sequence clears everything immediately.
        step(1, 4, 5, 0, 0, 0,            0, 0, 0);
        step(0, 4, 5, 0, 0, 0,            0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            logic r, we, ie, fl;
            int   a0, a1, wa, ia;
            r  = ($urandom_range(99) == 0);
            we = r ? 1'b0 : 1'($urandom_range(1));
            ie = 1'($urandom_range(1));
            fl = ($urandom_range(19) == 0);
            wa = $urandom_range(7);
            ia = $urandom_range(7);
            a0 = ($urandom_range(3) == 0) ? $urandom_range(31) : $urandom_range(7);
            a1 = ($urandom_range(1) == 0) ? wa : $urandom_range(7);
            step(r, a0, a1, we, wa, $urandom, ie, ia, fl);
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
